// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - column/row patterns, FSM encoding and index mapping for the keypad emulator
package keypad_pkg;

  localparam logic [3:0] C1       = 4'b0111;
  localparam logic [3:0] C2       = 4'b1011;
  localparam logic [3:0] C3       = 4'b1101;
  localparam logic [3:0] C4       = 4'b1110;
  localparam logic [3:0] IDLE_PAT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARM   = 2'b01,
    PRESS = 2'b10,
    GAP   = 2'b11
  } state_t;

  // Index 0 is the MSB line, matching the scanner's strobe order.
  function automatic logic [3:0] idx_to_low(input logic [1:0] idx);
    case (idx)
      2'd0:    return C1;
      2'd1:    return C2;
      2'd2:    return C3;
      default: return C4;
    endcase
  endfunction

endpackage

// File: rtl/keypad_col_edge.sv
// rtl/keypad_col_edge.sv - registers the column drive and flags strobe start/end on one column
module keypad_col_edge
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  input  logic [1:0] sel,
  output logic       act,
  output logic       deact
);

  logic [3:0] col_q;
  logic [3:0] sel_hot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= IDLE_PAT;
    end else begin
      col_q <= col;
    end
  end

  assign sel_hot = ~idx_to_low(sel);
  assign act     = |(sel_hot & col_q & ~col);
  assign deact   = |(sel_hot & ~col_q & col);

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 membrane keypad model closing one switch for a fixed number of column strobes
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_SCANS     = 4,
  parameter int GAP_SCANS      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] key_code,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  localparam int MAX_SCANS = (HOLD_SCANS > GAP_SCANS) ? HOLD_SCANS : GAP_SCANS;
  localparam int CNT_W     = $clog2(MAX_SCANS + 1);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] HOLD_N  = CNT_W'(HOLD_SCANS);
  localparam logic [CNT_W-1:0] GAP_N   = CNT_W'(GAP_SCANS);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nx;
  logic [3:0]       code_q, code_nx;
  logic [CNT_W-1:0] press_cnt, press_nx;
  logic [CNT_W-1:0] gap_cnt, gap_nx;
  logic [TO_W-1:0]  to_cnt, to_nx;

  logic       act, deact;
  logic       accept, expired, closed, col_low;
  logic [3:0] row_mask, col_mask;

  keypad_col_edge u_col_edge (
    .clk   (clk),
    .rst   (rst),
    .col   (col),
    .sel   (code_q[1:0]),
    .act   (act),
    .deact (deact)
  );

  assign key_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = key_valid & key_ready;
  // A strobe starting on the terminal count still counts, so act beats expiry.
  assign expired   = busy & ~act & (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      code_q    <= 4'd0;
      press_cnt <= '0;
      gap_cnt   <= '0;
      to_cnt    <= '0;
    end else begin
      state     <= state_nx;
      code_q    <= code_nx;
      press_cnt <= press_nx;
      gap_cnt   <= gap_nx;
      to_cnt    <= to_nx;
    end
  end

  always_comb begin
    state_nx = state;
    code_nx  = code_q;
    press_nx = press_cnt;
    gap_nx   = gap_cnt;
    to_nx    = to_cnt;
    done     = 1'b0;
    timeout  = 1'b0;

    if (busy) begin
      to_nx = act ? '0 : to_cnt + TO_W'(1);
    end

    case (state)
      IDLE: begin
        if (accept) begin
          code_nx  = key_code;
          press_nx = '0;
          gap_nx   = '0;
          to_nx    = '0;
          state_nx = ARM;
        end
      end
      ARM: begin
        if (act) begin
          press_nx = CNT_W'(1);
          state_nx = PRESS;
        end
      end
      PRESS: begin
        if (act) begin
          press_nx = press_cnt + CNT_W'(1);
        end else if (deact && (press_cnt == HOLD_N)) begin
          gap_nx = '0;
          if (GAP_SCANS == 0) begin
            done     = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = GAP;
          end
        end
      end
      GAP: begin
        if (deact) begin
          gap_nx = gap_cnt + CNT_W'(1);
          if ((gap_cnt + CNT_W'(1)) == GAP_N) begin
            done     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (expired) begin
      done     = 1'b0;
      timeout  = 1'b1;
      state_nx = IDLE;
    end
  end

  // Row follows the live column drive so the scanner sees no clock lag.
  assign closed   = (state == PRESS) | ((state == ARM) & act);
  assign row_mask = idx_to_low(code_q[3:2]);
  assign col_mask = idx_to_low(code_q[1:0]);
  assign col_low  = ((col | col_mask) != IDLE_PAT);
  assign row      = (closed & col_low) ? row_mask : IDLE_PAT;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - scoreboard bench for keypad_emulator
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_code;
  logic [3:0] col;
  logic       kv0, kv1, kv2;
  logic       rdy0, rdy1, rdy2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       to0, to1, to2;
  logic [3:0] row0, row1, row2;

  int          cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_emulator u_dut0 (
    .clk(clk), .rst(rst), .key_valid(kv0), .key_ready(rdy0), .key_code(key_code),
    .col(col), .row(row0), .busy(busy0), .done(done0), .timeout(to0)
  );

  keypad_emulator #(.TIMEOUT_CYCLES(16)) u_dut1 (
    .clk(clk), .rst(rst), .key_valid(kv1), .key_ready(rdy1), .key_code(key_code),
    .col(col), .row(row1), .busy(busy1), .done(done1), .timeout(to1)
  );

  keypad_emulator #(.HOLD_SCANS(1), .GAP_SCANS(0)) u_dut2 (
    .clk(clk), .rst(rst), .key_valid(kv2), .key_ready(rdy2), .key_code(key_code),
    .col(col), .row(row2), .busy(busy2), .done(done2), .timeout(to2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ev(input int id, input int c, input logic d,
                                     input logic t, input logic [3:0] r);
    return {18'd0, id[7:0], c[31:0], d, t, r};
  endfunction

  function automatic logic [3:0] pat(input int phase);
    logic [3:0] one;
    if (phase < 0) return 4'hF;
    one = 4'b1000 >> phase[1:0];
    return ~one;
  endfunction

  task automatic observe(input int id, input logic [3:0] r, input logic d, input logic t);
    logic [63:0] got;
    if ((r !== 4'hF) || (d !== 1'b0) || (t !== 1'b0)) begin
      got = ev(id, cyc, d, t, r);
      if (exp_q.size() == 0) check("unexpected_event", got, 64'd0);
      else check("event", got, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    observe(0, row0, done0, to0);
    observe(1, row1, done1, to1);
    observe(2, row2, done2, to2);
  end

  task automatic step(input int phase, input logic v0, input logic v1, input logic v2);
    @(posedge clk);
    #1;
    col = pat(phase);
    kv0 = v0;
    kv1 = v1;
    kv2 = v2;
  endtask

  task automatic start(input int id, input logic [3:0] code, input int phase, output int k);
    step(phase, id == 0, id == 1, id == 2);
    key_code = code;
    k = cyc;
  endtask

  // Closure on each target strobe, done on the strobe end that completes the gap.
  task automatic expect_press(input int id, input int fa, input int hold, input int gap,
                              input logic [3:0] r);
    for (int i = 0; i < hold; i++) exp_q.push_back(ev(id, fa + 4 * i, 1'b0, 1'b0, r));
    exp_q.push_back(ev(id, fa + 1 + 4 * (hold + gap - 1), 1'b1, 1'b0, 4'hF));
  endtask

  initial begin
    int k;
    kv0 = 1'b0;
    kv1 = 1'b0;
    kv2 = 1'b0;
    key_code = 4'd0;
    col = 4'hF;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_row", 64'({row0, row1, row2}), 64'h0FFF);
    check("rst_ready", 64'({rdy0, rdy1, rdy2}), 64'h7);
    check("rst_busy", 64'({busy0, busy1, busy2}), 64'h0);
    check("rst_pulses", 64'({done0, done1, done2, to0, to1, to2}), 64'h0);
    rst = 1'b1;
    step(-1, 1'b0, 1'b0, 1'b0);

    // key 0110 with a clean rotation
    start(0, 4'b0110, -1, k);
    expect_press(0, k + 3, 4, 2, 4'b1011);
    for (int i = 0; i < 24; i++) begin
      step(i, 1'b0, 1'b0, 1'b0);
      if (i == 10) check("t1_busy", 64'({rdy0, busy0}), 64'h1);
    end
    step(-1, 1'b0, 1'b0, 1'b0);
    check("t1_idle", 64'({rdy0, busy0}), 64'h2);

    // accept during an active strobe of the target column
    start(0, 4'b0000, 0, k);
    expect_press(0, k + 4, 4, 2, 4'b0111);
    for (int i = 1; i <= 25; i++) step(i, 1'b0, 1'b0, 1'b0);
    step(-1, 1'b0, 1'b0, 1'b0);
    check("t2_idle", 64'({rdy0, busy0}), 64'h2);

    // no column activity: timeout
    start(1, 4'b0101, -1, k);
    exp_q.push_back(ev(1, k + 16, 1'b0, 1'b1, 4'hF));
    for (int i = 0; i < 16; i++) step(-1, 1'b0, 1'b0, 1'b0);
    step(-1, 1'b0, 1'b0, 1'b0);
    check("t3_idle", 64'({rdy1, busy1}), 64'h2);

    // reset mid-press, then a fresh press
    start(0, 4'b0110, -1, k);
    exp_q.push_back(ev(0, k + 3, 1'b0, 1'b0, 4'b1011));
    for (int i = 0; i < 3; i++) step(i, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t4_async_row", 64'(row0), 64'hF);
    check("t4_async_ready", 64'({rdy0, busy0}), 64'h2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(-1, 1'b0, 1'b0, 1'b0);
    start(0, 4'b1111, -1, k);
    expect_press(0, k + 4, 4, 2, 4'b1110);
    for (int i = 0; i < 25; i++) step(i, 1'b0, 1'b0, 1'b0);
    step(-1, 1'b0, 1'b0, 1'b0);
    check("t4_idle", 64'({rdy0, busy0}), 64'h2);

    // key_valid held for three back-to-back requests
    start(0, 4'b1000, -1, k);
    for (int r = 0; r < 3; r++) expect_press(0, k + 1 + 24 * r, 4, 2, 4'b1101);
    for (int i = 0; i < 70; i++) begin
      step(i, 1'b1, 1'b0, 1'b0);
      check("t5_ready", 64'(rdy0), 64'(((i + 1) == 23) || ((i + 1) == 47)));
    end
    step(-1, 1'b0, 1'b0, 1'b0);
    check("t5_final_ready", 64'(rdy0), 64'h1);
    step(-1, 1'b0, 1'b0, 1'b0);
    check("t5_no_extra", 64'(busy0), 64'h0);

    // single strobe, no gap
    start(2, 4'b0000, -1, k);
    expect_press(2, k + 1, 1, 0, 4'b0111);
    step(0, 1'b0, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0, 1'b0);
    step(-1, 1'b0, 1'b0, 1'b0);
    check("t6_idle", 64'({rdy2, busy2}), 64'h2);

    repeat (3) step(-1, 1'b0, 1'b0, 1'b0);
    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Device-side model of a 4x4 membrane keypad: the opposite end of the column-scan/row-sense interface driven by the keypad scanner.
- Takes key-press commands over a valid/ready handshake and closes the chosen matrix switch for an exact number of column strobes, then releases it for a guard interval.
- Used on-board as a loopback stimulus source for the scanner/LED path, and in benches as the keypad model.

Parameters:
- HOLD_SCANS, 4: strobes of the target column during which the switch reads closed; legal range is 1 or more.
- GAP_SCANS, 2: strobes of the target column with the switch open before done; legal range is 0 or more.
- TIMEOUT_CYCLES, 1024: clocks without a target-column activation before the operation aborts; legal range is 2 or more.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_valid  in  1  press request valid.
- key_ready  out  1  high only in IDLE.
- key_code  in  4  [3:2] row index, [1:0] column index; captured when key_valid and key_ready are both high.
- col  in  4  column drive from the scanner, active-low, one-hot (0111, 1011, 1101, 1110) or idle 1111.
- row  out  4  row sense, active-low, idle 1111.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse on normal completion.
- timeout  out  1  one-cycle pulse on abort.

Behaviour:
- Index mapping matches the scanner order: column index i maps to col[3-i] (index 0 = 0111); row index j maps to row[3-j].
- Reset (rst=0, asynchronous):
  - State goes to IDLE; all counters clear; captured code clears to 0.
  - row=1111 immediately and combinationally; key_ready=1; busy=0; done=0; timeout=0.
  - Reset mid-press releases the switch in the same instant.
- col_q is col registered with reset value 1111.
- Activation edge (act): col_q[c]=1 and col[c]=0, where c is the captured column.
- Deactivation edge (deact): col_q[c]=0 and col[c]=1.
- Row output is combinational from col: row[3-j] = ~(closed & ~col[c]), where j is the captured row index. All other rows are 1.
- closed = (state==PRESS) | (state==ARM & act). Row therefore follows col with zero clock lag. Other columns being low at the same time (an illegal pattern) do not affect row.
- FSM:
  - IDLE: on accept, capture key_code, clear counters, go to ARM. No switch closure in the accept cycle.
  - ARM: wait for act. A strobe already in progress at accept is not used. On act, set press count to 1 and go to PRESS.
  - PRESS: each act increments the press count. On deact with press count == HOLD_SCANS, go to GAP with the gap count cleared; if GAP_SCANS==0, go directly to IDLE and pulse done.
  - GAP: switch is open; each deact increments the gap count. When the gap count reaches GAP_SCANS, pulse done and go to IDLE.
  - Result: exactly HOLD_SCANS complete target-column strobes read as closed.
- Timeout:
  - The cycle counter clears on accept and on every act, and increments otherwise in ARM, PRESS and GAP.
  - When the counter reaches TIMEOUT_CYCLES-1: pulse timeout, open the switch, go to IDLE.
  - If act and the terminal count occur in the same cycle, act wins and there is no timeout.
- done and timeout never assert in the same cycle.
- key_valid while busy is ignored; the requester holds the request.
- Counter widths: clog2 of (max(HOLD_SCANS, GAP_SCANS)+1) and clog2(TIMEOUT_CYCLES). No wrap occurs within legal ranges.

Decomposition:
- keypad_pkg holds:
  - the column-pattern constants C1..C4 and IDLE_PAT=1111;
  - the FSM state encoding (IDLE, ARM, PRESS, GAP; user encoding);
  - the index-to-one-hot-low mapping function.
- One sub-module: keypad_col_edge, which registers col and produces act/deact for a selected column index. The FSM, counters and row driver stay in keypad_emulator.

Test Plan:
- Default parameters; col rotates 0111→1011→1101→1110 one cycle each; accept key_code=0110 → row=1011 exactly in the cycles where col=1101, for 4 strobes. Then 2 more rotations with row=1111, then done=1 for one cycle and key_ready=1.
- key_code=0000 accepted while col=0111 is already active → that strobe leaves row=1111. Closure starts on the next 0111, and row=0111 appears in the same cycle as col=0111.
- col held at 1111 after accept, TIMEOUT_CYCLES=16 → timeout pulses on the 16th cycle after accept; row stays 1111; done is never asserted.
- rst pulled low for 1 cycle mid-PRESS while col=1101 and row=1011 → row=1111 asynchronously; key_ready=1 after reset. A new accept of 1111 then works: row=1110 appears on col=1110.
- key_valid held high for 3 requests back-to-back → each is accepted only in IDLE, with one done per request; key_ready=0 throughout each operation.
- GAP_SCANS=0 and HOLD_SCANS=1 → done pulses in the deact cycle of the single strobe.
